hazard_stall_ctrl: RTL

//  Pipeline hazard controller; drives the stall/flush inputs of the IF/ID, ID/EX and EX/MEM pipe registers.

---
 rtl/hazard_stall_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use bubble, mispredict flush sequencing and data-memory wait freeze.
// Define HAZARD_PERF_CNT_EN to add saturating stall-cycle and flush-event performance counters.
module hazard_stall_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] if_id_instr_i,
    input  logic        id_ex_mem_read_i,
    input  logic [4:0]  id_ex_rd_i,
    input  logic        branch_mispredict_i,
    input  logic        dmem_req_i,
    input  logic        dmem_ready_i,
    output logic        pc_stall_o,
    output logic        if_id_stall_o,
    output logic        id_ex_stall_o,
    output logic        ex_mem_stall_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic [1:0]  hazard_state_o,
    output logic        mem_timeout_err_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StFlush   = 2'd1,
        StMemWait = 2'd2,
        StUnused  = 2'd3
    } state_e;

    localparam logic [2:0]  FlushReload = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;
    localparam logic [15:0] TimeoutVal  = 16'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2;
    logic        uses_rs1, uses_rs2, load_use, mem_busy;
    logic        unused_instr_bits;

    assign opcode            = if_id_instr_i[6:0];
    assign rs1               = if_id_instr_i[19:15];
    assign rs2               = if_id_instr_i[24:20];
    assign unused_instr_bits = ^{if_id_instr_i[31:25], if_id_instr_i[14:7]};

    always_comb begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (opcode)
            7'b0110111, 7'b0010111, 7'b1101111: uses_rs1 = 1'b0;
            7'b0110011, 7'b0100011, 7'b1100011: uses_rs2 = 1'b1;
            default: ;
        endcase
    end

    assign load_use = id_ex_mem_read_i && (id_ex_rd_i != 5'd0) &&
                      ((uses_rs1 && (rs1 == id_ex_rd_i)) || (uses_rs2 && (rs2 == id_ex_rd_i)));
    assign mem_busy = dmem_req_i && !dmem_ready_i;

    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        err_d          = err_q;
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (branch_mispredict_i) begin
                    if_id_flush_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = StFlush;
                        flush_cnt_d = FlushReload;
                    end
                end else if (mem_busy) begin
                    pc_stall_o     = 1'b1;
                    if_id_stall_o  = 1'b1;
                    id_ex_stall_o  = 1'b1;
                    ex_mem_stall_o = 1'b1;
                    state_d        = StMemWait;
                    wait_cnt_d     = 16'd1;
                end else if (load_use) begin
                    // Hold decode and inject one bubble; the load reaches MEM next cycle.
                    pc_stall_o    = 1'b1;
                    if_id_stall_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                end
            end
            StFlush: begin
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
                if (flush_cnt_q == 3'd0) begin
                    state_d = StIdle;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            StMemWait: begin
                if (wait_cnt_q == TimeoutVal) begin
                    err_d = 1'b1;
                end
                if (dmem_ready_i) begin
                    state_d = StIdle;
                end else begin
                    pc_stall_o     = 1'b1;
                    if_id_stall_o  = 1'b1;
                    id_ex_stall_o  = 1'b1;
                    ex_mem_stall_o = 1'b1;
                    if (wait_cnt_q != 16'hFFFF) begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Reset must silence the pipe controls even though inputs may still request a stall.
        if (!rst_ni) begin
            pc_stall_o     = 1'b0;
            if_id_stall_o  = 1'b0;
            id_ex_stall_o  = 1'b0;
            ex_mem_stall_o = 1'b0;
            if_id_flush_o  = 1'b0;
            id_ex_flush_o  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            flush_cnt_q <= 3'd0;
            wait_cnt_q  <= 16'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
        end
    end

    assign hazard_state_o    = state_q;
    assign mem_timeout_err_o = err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            if (pc_stall_o && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if ((state_q == StIdle) && branch_mispredict_i && (perf_flush_q != 32'hFFFF_FFFF)) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt_o = perf_stall_q;
    assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule
